// File: rtl/chinx_io_ctrl.sv
// chinx_io_ctrl: memory-mapped controller for the four 8-bit IO ports.
// Req/ack access FSM, OUT/DIR registers and per-port input debounce.
module chinx_io_ctrl #(
    parameter int          DEB_CYCLES = 16,
    parameter logic [31:0] DIR_WMASK  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    input  logic [31:0] pin_in,
    output logic [31:0] pin_out,
    output logic [31:0] pin_oe
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACKNOW
    } state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  addr_q;
    logic [7:0]  wdata_q;

    logic [31:0] out_r;
    logic [31:0] dir_r;

    logic [31:0] sync1;
    logic [31:0] sync2;
    logic [31:0] deb;
    logic [7:0]  cnt [4];

    logic [4:0]  idx;
    logic [7:0]  dir_p;
    logic [7:0]  out_p;
    logic [7:0]  deb_p;
    logic [7:0]  rd_val;

    assign pin_out = out_r;
    assign pin_oe  = dir_r;

    // Select the latched port and form the read value: driven bits return OUT.
    always_comb begin
        idx    = {addr_q[1:0], 3'b000};
        dir_p  = dir_r[idx +: 8];
        out_p  = out_r[idx +: 8];
        deb_p  = deb[idx +: 8];
        rd_val = addr_q[2] ? dir_p : ((dir_p & out_p) | (~dir_p & deb_p));
    end

    // Access FSM: latch request, commit write or capture read, then pulse ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ack     <= 1'b0;
            rdata   <= 8'h00;
            we_q    <= 1'b0;
            addr_q  <= 3'b000;
            wdata_q <= 8'h00;
            out_r   <= 32'h0;
            dir_r   <= 32'h0;
        end else begin
            ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    rdata <= 8'h00;
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        rdata <= 8'h00;
                        if (addr_q[2])
                            dir_r[idx +: 8] <= wdata_q & DIR_WMASK[idx +: 8];
                        else
                            out_r[idx +: 8] <= wdata_q;
                    end else begin
                        rdata <= rd_val;
                    end
                    state <= ACKNOW;
                end
                ACKNOW: begin
                    ack   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus per-port debounce counter.
    // The load check comes before the restart check so a vector that has
    // been stable for DEB_CYCLES cycles is taken even if it moves next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 32'h0;
            sync2 <= 32'h0;
            deb   <= 32'h0;
            for (int p = 0; p < 4; p++) cnt[p] <= 8'h00;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
            for (int p = 0; p < 4; p++) begin
                if (sync2[8*p +: 8] == deb[8*p +: 8]) begin
                    cnt[p] <= 8'h00;
                end else if (cnt[p] == DEB_LAST) begin
                    deb[8*p +: 8] <= sync2[8*p +: 8];
                    cnt[p]        <= 8'h00;
                end else if (sync1[8*p +: 8] != sync2[8*p +: 8]) begin
                    cnt[p] <= 8'h00;
                end else if (cnt[p] != 8'hFF) begin
                    cnt[p] <= cnt[p] + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chinx_io_ctrl.sv
// tb_chinx_io_ctrl: directed bench for chinx_io_ctrl.
// Cycle model of transactions and debounce, plus literal checks.
module tb_chinx_io_ctrl;

    localparam int          DEB = 16;
    localparam logic [31:0] WM  = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'b000;
    logic [7:0]  wdata = 8'h00;
    logic        ack;
    logic [7:0]  rdata;
    logic [31:0] pin_in = 32'h0;
    logic [31:0] pin_out;
    logic [31:0] pin_oe;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    chinx_io_ctrl #(.DEB_CYCLES(DEB), .DIR_WMASK(WM)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .pin_in(pin_in),
        .pin_out(pin_out), .pin_oe(pin_oe)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a transaction accepted at edge t0 commits at
    // t0+1 and acks after t0+2; inputs settle once the synchronised
    // vector has held for DEB cycles.
    logic [7:0]  m_out [4];
    logic [7:0]  m_dir [4];
    logic [7:0]  m_deb [4];
    logic [7:0]  m_s1 [4];
    logic [7:0]  m_s2 [4];
    logic [7:0]  m_last [4];
    int          m_run [4];
    bit          m_pend = 0;
    int          m_k = 0;
    logic        m_we = 0;
    logic [2:0]  m_addr = 0;
    logic [7:0]  m_wd = 0;
    logic        m_ack = 0;
    logic [7:0]  m_rd = 0;
    logic [31:0] wm = WM;
    bit          live = 0;

    always @(posedge clk or negedge rst) begin
        int q;
        if (!rst) begin
            for (int p = 0; p < 4; p++) begin
                m_out[p] = 0; m_dir[p] = 0; m_deb[p] = 0;
                m_s1[p] = 0; m_s2[p] = 0; m_last[p] = 0; m_run[p] = 0;
            end
            m_pend = 0; m_ack = 0; m_rd = 0; m_k = 0;
        end else begin
            m_ack = 0;
            if (m_pend) begin
                m_k++;
                q = int'(m_addr[1:0]);
                if (m_k == 1) begin
                    if (m_we) begin
                        m_rd = 0;
                        if (m_addr[2]) m_dir[q] = m_wd & wm[8*q +: 8];
                        else m_out[q] = m_wd;
                    end else if (m_addr[2]) begin
                        m_rd = m_dir[q];
                    end else begin
                        for (int b = 0; b < 8; b++)
                            m_rd[b] = m_dir[q][b] ? m_out[q][b] : m_deb[q][b];
                    end
                end else begin
                    m_ack = 1;
                    m_pend = 0;
                end
            end else begin
                m_rd = 0;
                if (req) begin
                    m_pend = 1; m_k = 0;
                    m_we = we; m_addr = addr; m_wd = wdata;
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (m_s2[p] == m_last[p]) m_run[p]++;
                else m_run[p] = 1;
                m_last[p] = m_s2[p];
                if (m_s2[p] != m_deb[p] && m_run[p] >= DEB) m_deb[p] = m_s2[p];
                m_s2[p] = m_s1[p];
                m_s1[p] = pin_in[8*p +: 8];
            end
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        if (live) begin
            chk("ack", {31'b0, ack}, {31'b0, m_ack});
            chk("rdata", {24'b0, rdata}, {24'b0, m_rd});
            chk("pin_out", pin_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
            chk("pin_oe", pin_oe, {m_dir[3], m_dir[2], m_dir[1], m_dir[0]});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single transaction; starts and ends 1 time unit after a clk edge.
    task automatic xact(input logic w, input logic [2:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output int lat);
        req = 1; we = w; addr = a; wdata = d;
        lat = 0; rd = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i; rd = rdata;
                break;
            end
        end
        req = 0;
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL xact_timeout addr=%h", a);
        end
    endtask

    logic [7:0] rd;
    int         lat;
    logic [7:0] rds [8];
    int         n;
    int         l1;
    int         l2;

    initial begin
        #1 rst = 0;
        live = 1;
        #1;
        chk("rst_oe_async", pin_oe, 32'h0);
        tick(2);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_rdata", {24'b0, rdata}, 32'h0);
        @(negedge clk) rst = 1;
        tick(1);

        // DIR read of port 2 after reset
        xact(0, 3'b110, 8'h00, rd, lat);
        chk("lat_first", lat, 3);
        chk("dir2_rd", {24'b0, rd}, 32'h0);
        chk("oe_zero", pin_oe, 32'h0);

        // DIR/DATA of port 1, mixed read
        xact(1, 3'b101, 8'h0F, rd, lat);
        xact(1, 3'b001, 8'hA5, rd, lat);
        chk("oe_p1", {24'b0, pin_oe[15:8]}, 32'h0F);
        chk("out_p1", {24'b0, pin_out[15:8]}, 32'hA5);
        pin_in[15:8] = 8'h30;
        tick(DEB + 6);
        xact(0, 3'b001, 8'h00, rd, lat);
        chk("data_p1_mix", {24'b0, rd}, 32'h35);

        // masked DIR on port 0
        xact(1, 3'b100, 8'hFF, rd, lat);
        xact(0, 3'b100, 8'h00, rd, lat);
        chk("dir0_masked", {24'b0, rd}, 32'h00);
        chk("oe_p0_masked", {24'b0, pin_oe[7:0]}, 32'h00);

        // input step with back-to-back reads of port 0
        req = 1; we = 0; addr = 3'b000;
        pin_in[2:0] = 3'b101;
        n = 0;
        for (int i = 0; i < 40 && n < 7; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                rds[n] = rdata;
                n++;
                if (n == 7) req = 0;
            end
        end
        req = 0;
        chk("step_reads", n, 7);
        chk("step_first", {24'b0, rds[0]}, 32'h00);
        chk("step_edge17", {24'b0, rds[5]}, 32'h00);
        chk("step_edge20", {24'b0, rds[6]}, 32'h05);

        // 10-cycle glitch is filtered
        pin_in[2:0] = 3'b000;
        tick(10);
        pin_in[2:0] = 3'b101;
        tick(DEB + 8);
        xact(0, 3'b000, 8'h00, rd, lat);
        chk("glitch", {24'b0, rd}, 32'h05);

        // req held across ack gives a second transaction
        xact(1, 3'b111, 8'hFF, rd, lat);
        xact(1, 3'b011, 8'h11, rd, lat);
        req = 1; we = 0; addr = 3'b111;
        l1 = 0; l2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                if (l1 == 0) l1 = i;
                else begin
                    l2 = i;
                    chk("held_rd", {24'b0, rdata}, 32'hFF);
                    req = 0;
                    break;
                end
            end
        end
        req = 0;
        chk("held_first", l1, 3);
        chk("held_gap", l2 - l1, 3);

        // reset in ACCESS of a DATA write
        tick(1);
        req = 1; we = 1; addr = 3'b011; wdata = 8'hFF;
        @(posedge clk); #1;
        rst = 0;
        req = 0;
        #1;
        chk("rst_mid_oe", pin_oe, 32'h0);
        chk("rst_mid_out", pin_out, 32'h0);
        chk("rst_mid_ack", {31'b0, ack}, 32'h0);
        tick(2);
        chk("rst_mid_noack", {31'b0, ack}, 32'h0);
        @(negedge clk) rst = 1;
        tick(1);
        xact(0, 3'b111, 8'h00, rd, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_dir3", {24'b0, rd}, 32'h00);
        xact(1, 3'b011, 8'h5A, rd, lat);
        chk("post_rst_out3", {24'b0, pin_out[31:24]}, 32'h5A);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
